// File: rtl/psram_pkg.sv
// psram_pkg: shared state encodings and frame geometry for the PSDRAM frame buffer.
// Used by psram_frame_writer, psram_wr_cycle and the VGA scan-out reader.
package psram_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_REQ,
        S_SETUP,
        S_WRITE,
        S_HOLD,
        S_VERIFY
    } state_t;
    localparam int P_IMAGE1 = 1078;
    localparam int P_HLINES = 640;
    localparam int P_VLINES = 480;
    function automatic int frame_words(input int hlines, input int vlines);
        return hlines * vlines / 2;
    endfunction
endpackage

// File: rtl/psram_wr_cycle.sv
// psram_wr_cycle: sequences one async-SRAM-style PSDRAM write (SETUP, WRITE, HOLD, optional VERIFY read-back).
// Ports: clk_25Mhz/reset (async, active-high); go latches adr/data and starts a cycle from idle;
// done is high in the final clock of the cycle; Mem*/Ram* are registered PSDRAM strobes (active-low enables).
// With PSRAM_WRITE_VERIFY_EN defined, MemDataIn is read back and err flags a mismatch alongside done.
module psram_wr_cycle
    import psram_pkg::*;
#(
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 3
) (
    input  logic        clk_25Mhz,
    input  logic        reset,
    input  logic        go,
    input  logic [22:0] adr,
    input  logic [15:0] data,
`ifdef PSRAM_WRITE_VERIFY_EN
    input  logic [15:0] MemDataIn,
    output logic        err,
`endif
    output logic        done,
    output logic [22:0] MemAdr,
    output logic [15:0] MemDataOut,
    output logic        MemDataOE,
    output logic        MemWR,
    output logic        MemOE,
    output logic        RamCE,
    output logic        RamLB,
    output logic        RamUB
);
    localparam int CW = $clog2(((WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES) + 1);

    state_t        st;
    logic [CW-1:0] cnt;

`ifdef PSRAM_WRITE_VERIFY_EN
    assign done = (st == S_VERIFY) && (cnt == '0);
    assign err  = done && (MemDataIn != MemDataOut);
`else
    assign done = (st == S_HOLD);
`endif

    always_ff @(posedge clk_25Mhz or posedge reset) begin
        if (reset) begin
            st         <= S_IDLE;
            cnt        <= '0;
            MemAdr     <= '0;
            MemDataOut <= '0;
            MemDataOE  <= 1'b0;
            MemWR      <= 1'b1;
            MemOE      <= 1'b1;
            RamCE      <= 1'b1;
            RamLB      <= 1'b1;
            RamUB      <= 1'b1;
        end else begin
            case (st)
                S_IDLE: if (go) begin
                    st         <= S_SETUP;
                    MemAdr     <= adr;
                    MemDataOut <= data;
                    MemDataOE  <= 1'b1;
                    RamCE      <= 1'b0;
                    RamLB      <= 1'b0;
                    RamUB      <= 1'b0;
                end
                S_SETUP: begin
                    st    <= S_WRITE;
                    MemWR <= 1'b0;
                    cnt   <= CW'(WR_CYCLES - 1);
                end
                S_WRITE: if (cnt == '0) begin
                    st    <= S_HOLD;
                    MemWR <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
`ifdef PSRAM_WRITE_VERIFY_EN
                // Keep CE asserted and turn the bus around for the read-back.
                S_HOLD: begin
                    st        <= S_VERIFY;
                    MemDataOE <= 1'b0;
                    MemOE     <= 1'b0;
                    cnt       <= CW'(RD_CYCLES - 1);
                end
                S_VERIFY: if (cnt == '0) begin
                    st    <= S_IDLE;
                    MemOE <= 1'b1;
                    RamCE <= 1'b1;
                    RamLB <= 1'b1;
                    RamUB <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
`else
                S_HOLD: begin
                    st        <= S_IDLE;
                    MemDataOE <= 1'b0;
                    RamCE     <= 1'b1;
                    RamLB     <= 1'b1;
                    RamUB     <= 1'b1;
                end
`endif
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/psram_frame_writer.sv
// psram_frame_writer: packs an 8-bit pixel stream into 16-bit words and writes one frame to PSDRAM per start pulse.
// Ports: clk_25Mhz, reset (async, active-high); start pulse; pix_data/pix_valid/pix_ready stream in
// (even pixel -> [7:0], odd pixel -> [15:8]); bus_req/bus_gnt arbiter handshake; Mem*/Ram* PSDRAM pins;
// busy during a frame load, frame_done one-cycle pulse after the last word.
// Optional macro PSRAM_WRITE_VERIFY_EN adds read-back verify with verify_err (sticky) and err_cnt (saturating).
module psram_frame_writer
    import psram_pkg::*;
#(
    parameter int BASE_ADDR = P_IMAGE1,
    parameter int HLINES    = P_HLINES,
    parameter int VLINES    = P_VLINES,
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 3
) (
    input  logic        clk_25Mhz,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [22:0] MemAdr,
    output logic [15:0] MemDataOut,
    output logic        MemDataOE,
    input  logic [15:0] MemDataIn,
    output logic        MemWR,
    output logic        MemOE,
    output logic        RamCE,
    output logic        RamLB,
    output logic        RamUB,
`ifdef PSRAM_WRITE_VERIFY_EN
    output logic        verify_err,
    output logic [15:0] err_cnt,
`endif
    output logic        busy,
    output logic        frame_done
);
    localparam int          WORDS     = frame_words(HLINES, VLINES);
    localparam logic [17:0] LAST_WORD = 18'(WORDS - 1);

    // S_SETUP here means "a memory cycle is in flight in psram_wr_cycle".
    state_t      state;
    logic        phase;
    logic [15:0] word;
    logic [17:0] word_cnt;
    logic        go;
    logic        done;
    logic [22:0] adr;

    assign go  = (state == S_REQ) && bus_gnt;
    assign adr = 23'(BASE_ADDR) + {5'd0, word_cnt};

`ifdef PSRAM_WRITE_VERIFY_EN
    logic err;
`else
    logic unused_din;
    assign unused_din = ^MemDataIn;
`endif

    psram_wr_cycle #(
        .WR_CYCLES(WR_CYCLES),
        .RD_CYCLES(RD_CYCLES)
    ) u_cycle (
        .clk_25Mhz (clk_25Mhz),
        .reset     (reset),
        .go        (go),
        .adr       (adr),
        .data      (word),
`ifdef PSRAM_WRITE_VERIFY_EN
        .MemDataIn (MemDataIn),
        .err       (err),
`endif
        .done      (done),
        .MemAdr    (MemAdr),
        .MemDataOut(MemDataOut),
        .MemDataOE (MemDataOE),
        .MemWR     (MemWR),
        .MemOE     (MemOE),
        .RamCE     (RamCE),
        .RamLB     (RamLB),
        .RamUB     (RamUB)
    );

    always_ff @(posedge clk_25Mhz or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            phase      <= 1'b0;
            word       <= '0;
            word_cnt   <= '0;
            pix_ready  <= 1'b0;
            bus_req    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef PSRAM_WRITE_VERIFY_EN
            verify_err <= 1'b0;
            err_cnt    <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state     <= S_ACCEPT;
                    word_cnt  <= '0;
                    phase     <= 1'b0;
                    busy      <= 1'b1;
                    pix_ready <= 1'b1;
`ifdef PSRAM_WRITE_VERIFY_EN
                    verify_err <= 1'b0;
                    err_cnt    <= '0;
`endif
                end
                S_ACCEPT: if (pix_valid && pix_ready) begin
                    phase <= ~phase;
                    if (!phase) begin
                        word[7:0] <= pix_data;
                    end else begin
                        word[15:8] <= pix_data;
                        pix_ready  <= 1'b0;
                        bus_req    <= 1'b1;
                        state      <= S_REQ;
                    end
                end
                S_REQ: if (bus_gnt) state <= S_SETUP;
                default: begin
`ifdef PSRAM_WRITE_VERIFY_EN
                    if (err) begin
                        verify_err <= 1'b1;
                        err_cnt    <= err_cnt + {15'd0, err_cnt != 16'hFFFF};
                    end
`endif
                    if (done) begin
                        bus_req  <= 1'b0;
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            state      <= S_IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            state     <= S_ACCEPT;
                            pix_ready <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule
